spi_frame_buffer: RTL and testbench
===================================

Name: spi_frame_buffer

Overview:
SPI-slave front end feeding the neopixel driver. It receives one frame of GRB bytes over SPI mode 0 and writes it into the back bank of a double-buffered byte RAM. On a valid frame it swaps banks and pulses the driver's start input. The front bank serves the driver's read port (address in, byte out, 1-cycle latency), so a new frame can be received while the previous one is still shifting out.

Parameters:
LEDS, 200, number of pixels; frame length FRAME_BYTES = LEDS*3.
SYNC_STAGES, 2, flip-flop stages on each asynchronous SPI input (minimum 2).

Ports:
i_clk  in  1  system clock (50 MHz nominal).
i_rst_n  in  1  asynchronous active-low reset.
i_spi_sclk  in  1  SPI clock, asynchronous; idle low; f_sclk <= f_clk/8.
i_spi_mosi  in  1  SPI data; sampled on SCLK rising edge; MSB first.
i_spi_cs_n  in  1  SPI chip select, active low; one transaction = one frame.
i_rd_addr  in  $clog2(LEDS*3)  driver read address; byte 0 is the first byte on the wire.
o_rd_data  out  8  front-bank byte at i_rd_addr, registered.
i_drv_busy  in  1  driver busy flag.
o_start  out  1  one-cycle pulse to driver i_start.
o_frame_err  out  1  one-cycle pulse when a transaction is rejected.
o_front_bank  out  1  index of the bank currently being read.

Behaviour:
- Reset (asynchronous, active low): o_start=0, o_frame_err=0, o_front_bank=0, o_rd_data=0; byte counter, bit counter, shift register, pending flag and state cleared; synchronizers cleared to SCLK=0, CS_n=1. RAM contents are not cleared.
- Inputs pass through SYNC_STAGES FFs. Edges are detected on the synchronized signals against a 1-cycle-delayed copy.
- States:
  - IDLE: wait for CS_n falling edge, then clear byte_cnt and bit_cnt and enter RECV.
  - RECV:
    - On each SCLK rising edge, shift MOSI into the LSB.
    - On the 8th bit, write the byte to back[byte_cnt] on the next cycle if byte_cnt < FRAME_BYTES. byte_cnt saturates at FRAME_BYTES.
    - On CS_n rising edge, enter CHECK.
  - CHECK (1 cycle):
    - Valid iff byte_cnt == FRAME_BYTES and bit_cnt == 0.
    - Invalid (short, long, or partial byte): pulse o_frame_err and return to IDLE; the back bank is not swapped.
    - Valid: enter COMMIT.
  - COMMIT: wait while i_drv_busy=1. In the first cycle with i_drv_busy=0, toggle o_front_bank; o_start=1 in the following cycle for exactly one cycle; then return to IDLE.
- Overlong frames: bytes beyond FRAME_BYTES are discarded, not written, and make the frame invalid.
- A CS_n falling edge while in COMMIT is not accepted. Its whole transaction is dropped (no RAM writes) and o_frame_err pulses at its CS_n rise. The pending frame still commits.
- Read port: o_rd_data <= front[i_rd_addr] every cycle, 1-cycle latency. Writes only ever target the back bank, so read and write never collide.
- The bank swap happens only while the driver is idle, so a frame in progress never changes banks mid-stream.
- Reset mid-transaction: the partial frame is lost. If CS_n is already low when reset releases, the block stays in IDLE until the next CS_n falling edge.
- Widths: byte_cnt is $clog2(FRAME_BYTES+1) bits so that it can hold FRAME_BYTES; bit_cnt is 3 bits and wraps 7->0.

Decomposition:
- Shared package spi_led_pkg holds:
  - the state enum (IDLE, RECV, CHECK, COMMIT);
  - the FRAME_BYTES derivation;
  - the byte type.
- Neopixel timing constants also move into spi_led_pkg.
- One natural sub-module: dpram_2bank, a simple dual-port RAM with a write port and a registered read port, holding 2*FRAME_BYTES bytes. Its address is {bank, addr}, and it infers block RAM.

Test Plan:
- LEDS=4: send 12 bytes 0x01..0x0C with i_drv_busy=0. Required: o_front_bank goes 0->1, then o_start pulses one cycle later, and reading addr 0..11 returns 0x01..0x0C.
- LEDS=4: send 11 bytes. Required: o_frame_err pulses once, no o_start, o_front_bank unchanged.
- LEDS=4: send 13 bytes. Required: o_frame_err pulses, and the 13th byte never appears in either bank.
- Frame with i_drv_busy=1 held for 500 cycles. Required: no swap and no o_start until busy drops; swap occurs in the first non-busy cycle, o_start follows one cycle later.
- Second transaction sent while COMMIT is pending. Required: no RAM writes, o_frame_err at its CS_n rise, and the first frame still commits.
- Assert i_rst_n=0 after 5 bytes. Required: all outputs are 0 immediately (asynchronous); after release, a full valid frame commits normally into bank 1.

Source files
------------

// File: rtl/spi_led_pkg.sv
// Shared types and constants for the SPI-fed neopixel path: FSM states, byte type,
// frame size derivation and WS2812 bit timing at a 50 MHz core clock.
package spi_led_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RECV   = 2'd1,
        CHECK  = 2'd2,
        COMMIT = 2'd3
    } state_t;

    localparam int LEDS_DEFAULT = 200;

    function automatic int frame_bytes(input int leds);
        return leds * 3;
    endfunction

    localparam int FRAME_BYTES = frame_bytes(LEDS_DEFAULT);

    // WS2812 symbol timing in 20 ns core-clock cycles.
    localparam int CLK_HZ        = 50_000_000;
    localparam int T0H_CYC       = 20;
    localparam int T0L_CYC       = 42;
    localparam int T1H_CYC       = 40;
    localparam int T1L_CYC       = 22;
    localparam int RESET_CYC     = 2500;

endpackage

// File: rtl/dpram_2bank.sv
// Two-bank byte RAM: one write port, one registered read port, address = {bank, addr}.
// Read latency 1 cycle; no backpressure (both ports accept every cycle).
module dpram_2bank #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW:0]   waddr,
    input  logic [7:0]    wdata,
    input  logic [AW:0]   raddr,
    output logic [7:0]    rdata
);

    // Each bank spans the full power-of-two window so {bank, addr} indexes directly.
    logic [7:0] mem [2**(AW+1)];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= 8'h00;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/spi_frame_buffer.sv
// SPI mode-0 slave that captures one GRB frame per CS_n transaction into the back bank
// and swaps banks / pulses o_start once the driver is idle; read port latency 1 cycle.
module spi_frame_buffer
    import spi_led_pkg::*;
#(
    parameter int LEDS        = 200,
    parameter int SYNC_STAGES = 2
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_spi_sclk,
    input  logic                      i_spi_mosi,
    input  logic                      i_spi_cs_n,
    input  logic [$clog2(LEDS*3)-1:0] i_rd_addr,
    output logic [7:0]                o_rd_data,
    input  logic                      i_drv_busy,
    output logic                      o_start,
    output logic                      o_frame_err,
    output logic                      o_front_bank
);

    localparam int FB   = frame_bytes(LEDS);
    localparam int AW   = $clog2(FB);
    localparam int BW   = $clog2(FB + 1);
    localparam int SS   = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam int WARM = SS + 1;
    localparam int WW   = $clog2(WARM + 1);

    localparam logic [BW-1:0] FB_CNT   = BW'(FB);
    localparam logic [WW-1:0] WARM_CNT = WW'(WARM);

    logic [SS-1:0] sclk_sync, mosi_sync, cs_sync;
    logic          sclk_s, mosi_s, cs_s;
    logic          sclk_d, cs_d;
    logic [WW-1:0] warm_cnt;
    logic          armed, sclk_rise, cs_fall, cs_rise;

    state_t        state, next_state;
    logic [BW-1:0] byte_cnt;
    logic [2:0]    bit_cnt;
    byte_t         shift;
    logic          overflow;
    logic          drop;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic          start_pend;

    logic          frame_ok, swap, err_set, drop_set;

    assign sclk_s = sclk_sync[SS-1];
    assign mosi_s = mosi_sync[SS-1];
    assign cs_s   = cs_sync[SS-1];

    // Until the reset-filled synchronizers have flushed, a low CS_n is not a real edge.
    assign armed     = (warm_cnt == WARM_CNT);
    assign sclk_rise = sclk_s & ~sclk_d;
    assign cs_fall   = armed & ~cs_s & cs_d;
    assign cs_rise   = cs_s & ~cs_d;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sclk_sync <= '0;
            mosi_sync <= '0;
            cs_sync   <= '1;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b1;
            warm_cnt  <= '0;
        end else begin
            sclk_sync <= {sclk_sync[SS-2:0], i_spi_sclk};
            mosi_sync <= {mosi_sync[SS-2:0], i_spi_mosi};
            cs_sync   <= {cs_sync[SS-2:0], i_spi_cs_n};
            sclk_d    <= sclk_s;
            cs_d      <= cs_s;
            if (!armed) begin
                warm_cnt <= warm_cnt + WW'(1);
            end
        end
    end

    assign frame_ok = (byte_cnt == FB_CNT) && (bit_cnt == 3'd0) && !overflow;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        swap       = 1'b0;
        err_set    = 1'b0;
        drop_set   = 1'b0;
        case (state)
            IDLE:   if (cs_fall) next_state = RECV;
            RECV:   if (cs_rise) next_state = CHECK;
            CHECK: begin
                if (frame_ok) begin
                    next_state = COMMIT;
                end else begin
                    next_state = IDLE;
                    err_set    = 1'b1;
                end
            end
            COMMIT: begin
                drop_set = cs_fall;
                if (!i_drv_busy) begin
                    swap       = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
        // A transaction that began during COMMIT is rejected when it ends.
        if (drop && cs_rise) begin
            err_set = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            byte_cnt     <= '0;
            bit_cnt      <= '0;
            shift        <= '0;
            overflow     <= 1'b0;
            drop         <= 1'b0;
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            start_pend   <= 1'b0;
            o_start      <= 1'b0;
            o_frame_err  <= 1'b0;
            o_front_bank <= 1'b0;
        end else begin
            wr_en       <= 1'b0;
            start_pend  <= swap;
            o_start     <= start_pend;
            o_frame_err <= err_set;

            if (state == IDLE && cs_fall) begin
                byte_cnt <= '0;
                bit_cnt  <= '0;
                overflow <= 1'b0;
            end

            if (state == RECV && sclk_rise) begin
                shift   <= {shift[6:0], mosi_s};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    if (byte_cnt < FB_CNT) begin
                        wr_en    <= 1'b1;
                        wr_addr  <= byte_cnt[AW-1:0];
                        byte_cnt <= byte_cnt + BW'(1);
                    end else begin
                        overflow <= 1'b1;
                    end
                end
            end

            if (drop_set) begin
                drop <= 1'b1;
            end else if (cs_rise) begin
                drop <= 1'b0;
            end

            if (swap) begin
                o_front_bank <= ~o_front_bank;
            end
        end
    end

    // The completed byte sits in shift the cycle after its 8th bit; the bank
    // cannot swap during RECV, so ~o_front_bank is stable for the whole frame.
    dpram_2bank #(
        .AW (AW)
    ) u_ram (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .we    (wr_en),
        .waddr ({~o_front_bank, wr_addr}),
        .wdata (shift),
        .raddr ({o_front_bank, i_rd_addr}),
        .rdata (o_rd_data)
    );

endmodule

// File: tb/tb_spi_frame_buffer.sv
// Directed-random bench for spi_frame_buffer with LEDS=4 (12-byte frames) and a
// bank-level reference model of what each transaction should leave in RAM.
module tb_spi_frame_buffer;

    localparam int LEDS = 4;
    localparam int FB   = LEDS * 3;
    localparam int AW   = $clog2(FB);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          sclk = 1'b0;
    logic          mosi = 1'b0;
    logic          cs_n = 1'b1;
    logic [AW-1:0] rd_addr = '0;
    logic [7:0]    rd_data;
    logic          busy = 1'b0;
    logic          start;
    logic          frame_err;
    logic          front_bank;

    spi_frame_buffer #(
        .LEDS        (LEDS),
        .SYNC_STAGES (2)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_spi_sclk   (sclk),
        .i_spi_mosi   (mosi),
        .i_spi_cs_n   (cs_n),
        .i_rd_addr    (rd_addr),
        .o_rd_data    (rd_data),
        .i_drv_busy   (busy),
        .o_start      (start),
        .o_frame_err  (frame_err),
        .o_front_bank (front_bank)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Output monitor, sampled on the falling edge.
    int   cyc = 0;
    int   start_cnt = 0, err_cnt = 0, start_wide = 0;
    int   start_cyc = -1, swap_cyc = -1;
    logic start_prev = 1'b0;
    logic front_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (start) begin
            start_cnt = start_cnt + 1;
            start_cyc = cyc;
            if (start_prev) start_wide = start_wide + 1;
        end
        start_prev = start;
        if (frame_err) err_cnt = err_cnt + 1;
        if (front_bank !== front_prev) begin
            swap_cyc   = cyc;
            front_prev = front_bank;
        end
    end

    // Reference model: contents of both banks and which one is in front.
    logic [7:0] mem_m [2][FB];
    logic       front_m = 1'b0;
    logic [7:0] frm [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic make_frame(input int n);
        frm.delete();
        for (int i = 0; i < n; i++) frm.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic spi_bits(input logic [7:0] b, input int nbits);
        for (int i = 7; i > 7 - nbits; i--) begin
            @(negedge clk);
            mosi = b[i];
            repeat (8) @(negedge clk);
            sclk = 1'b1;
            repeat (8) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    task automatic cs_begin();
        @(negedge clk);
        cs_n = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic cs_end();
        repeat (8) @(negedge clk);
        cs_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic send_frame(input int extra_bits);
        cs_begin();
        foreach (frm[i]) spi_bits(frm[i], 8);
        if (extra_bits > 0) spi_bits(8'($urandom_range(0, 255)), extra_bits);
        cs_end();
    endtask

    // Whole bytes up to the frame length land in the back bank; the frame is
    // good only if it is exactly FB whole bytes.
    function automatic bit model_txn(input bit dropped, input int extra_bits);
        if (dropped) return 1'b0;
        for (int i = 0; i < frm.size() && i < FB; i++) mem_m[~front_m][i] = frm[i];
        return (frm.size() == FB) && (extra_bits == 0);
    endfunction

    task automatic wait_start(input int prev, input string tag);
        int budget = 2000;
        while (start_cnt == prev && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check(tag, start_cnt, prev + 1);
    endtask

    task automatic check_bank(input string tag);
        check({tag, "_front"}, 32'(front_bank), 32'(front_m));
        for (int a = 0; a < FB; a++) begin
            @(negedge clk);
            rd_addr = AW'(a);
            @(negedge clk);
            check($sformatf("%s_rd%0d", tag, a), 32'(rd_data), 32'(mem_m[front_m][a]));
        end
    endtask

    initial begin
        int  s0, e0, drop_cyc;
        bit  ok;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_start", 32'(start), 0);
        check("rst_err", 32'(frame_err), 0);
        check("rst_front", 32'(front_bank), 0);
        check("rst_rd", 32'(rd_data), 0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // 1: fixed frame 0x01..0x0C, driver idle
        frm.delete();
        for (int i = 1; i <= FB; i++) frm.push_back(8'(i));
        s0 = start_cnt;
        send_frame(0);
        ok = model_txn(1'b0, 0);
        front_m = ~front_m;
        wait_start(s0, "fixed_start");
        check("fixed_valid", 32'(ok), 1);
        check("fixed_swap_to_start", 32'(start_cyc - swap_cyc), 1);
        check_bank("fixed");

        // 2: random valid frame swaps back to bank 0
        make_frame(FB);
        s0 = start_cnt;
        send_frame(0);
        if (model_txn(1'b0, 0)) front_m = ~front_m;
        wait_start(s0, "rand_start");
        check_bank("rand");

        // 3: short, long and partial-byte frames are rejected without swap
        for (int k = 0; k < 3; k++) begin
            make_frame(k == 0 ? FB - 1 : (k == 1 ? FB + 1 : FB));
            s0 = start_cnt;
            e0 = err_cnt;
            send_frame(k == 2 ? 3 : 0);
            ok = model_txn(1'b0, k == 2 ? 3 : 0);
            repeat (20) @(negedge clk);
            check($sformatf("bad%0d_err", k), err_cnt, e0 + 1);
            check($sformatf("bad%0d_nostart", k), start_cnt, s0);
            check_bank($sformatf("bad%0d", k));
        end

        // 4: driver busy for 500 cycles holds off the swap
        busy = 1'b1;
        make_frame(FB);
        s0 = start_cnt;
        send_frame(0);
        ok = model_txn(1'b0, 0);
        repeat (500) @(negedge clk);
        check("busy_noswap", 32'(front_bank), 32'(front_m));
        check("busy_nostart", start_cnt, s0);
        busy = 1'b0;
        drop_cyc = cyc;
        front_m = ~front_m;
        wait_start(s0, "busy_start");
        check("busy_swap_cyc", swap_cyc - drop_cyc, 1);
        check("busy_start_cyc", start_cyc - drop_cyc, 2);
        check_bank("busy");

        // 5: second transaction while commit is pending is dropped
        busy = 1'b1;
        make_frame(FB);
        s0 = start_cnt;
        send_frame(0);
        ok = model_txn(1'b0, 0);
        e0 = err_cnt;
        make_frame(FB);
        send_frame(0);
        ok = model_txn(1'b1, 0);
        check("pend_err", err_cnt, e0 + 1);
        check("pend_noswap", 32'(front_bank), 32'(front_m));
        busy = 1'b0;
        front_m = ~front_m;
        wait_start(s0, "pend_start");
        check_bank("pend");

        // 6: reset after 5 bytes; CS_n still low at release must not start a frame
        make_frame(5);
        cs_begin();
        foreach (frm[i]) spi_bits(frm[i], 8);
        ok = model_txn(1'b0, 0);
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_start", 32'(start), 0);
        check("arst_err", 32'(frame_err), 0);
        check("arst_front", 32'(front_bank), 0);
        check("arst_rd", 32'(rd_data), 0);
        front_m = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        s0 = start_cnt;
        e0 = err_cnt;
        for (int i = 0; i < 3; i++) spi_bits(8'($urandom_range(0, 255)), 8);
        cs_end();
        check("arst_idle_err", err_cnt, e0);
        check("arst_idle_start", start_cnt, s0);
        make_frame(FB);
        send_frame(0);
        if (model_txn(1'b0, 0)) front_m = ~front_m;
        wait_start(s0, "arst_start_pulse");
        check_bank("arst");

        check("start_width", start_wide, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
